code_serializer: RTL

Downstream stage for the 4-bit code encoder: captures each code word the encoder presents on its `ready` strobe, buffers it in a small FIFO, and transmits it as a fixed-format serial frame on a single line. The block decouples the encoder's bursty, strobe-driven output from a slow bit-serial link. It runs on one clock and adds framing: start bit, LSB-first data, even parity, stop bit.

---
 rtl/code_serializer_pkg.sv | 20 ++
 rtl/code_fifo.sv | 61 ++++++
 rtl/code_serializer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/code_serializer_pkg.sv
// Shared types and constants for the code word serializer.
// Frame layout: start, DATA_BITS data bits LSB-first, even parity, stop.
package code_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int FRAME_BITS = 7;
  localparam int DATA_BITS  = 4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Circular FIFO with occupancy count. A push while full is accepted only
// if a pop happens in the same cycle; otherwise it is reported on drop_o.
module code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_q];

  // A pop frees the head slot this cycle, so a simultaneous push fits even when full.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;

  always_comb begin
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    level_d = level_q + {AW'(0), do_push} - {AW'(0), do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/code_serializer.sv
// Captures encoder code words on rising edges of ready, queues them, and
// sends each as a start / 4 data (LSB first) / even parity / stop frame on tx.
module code_serializer
  import code_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             S,
  input  logic                   ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   ready_q;
  logic                   ovf_q;

  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   last_clk;
  logic [DATA_BITS-1:0]   head;

  // ready_q resets high so a strobe held through reset is not a rising edge.
  assign push     = ready & ~ready_q;
  assign last_clk = (cnt_q == CW'(CLKS_PER_BIT - 1));

  code_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (S),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level),
    .drop_o  (drop)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          par_d   = even_parity(head);
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (last_clk) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (last_clk) begin
          cnt_d = '0;
          if (bit_q == 2'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end else begin
            sh_d  = sh_q >> 1;
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_clk) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (last_clk) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // tx is registered from the next state so it changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ready_q <= ready;
      ovf_q   <= ovf_q | drop;
    end
  end

  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    par_q <= par_d;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule
